// File: rtl/sudoku_pkg.sv
// sudoku_pkg
//   Shared types and width constants for the sudoku game controller.
//   - state_e   : FSM state encodings (the numeric values appear on the state port)
//   - button_e  : the single button selected each cycle after priority resolution
//   - dir_e     : cursor move direction handed to cursor_mover
//   - PW/NW/CW  : position, number and hidden-cell-count widths, sized for grids up to GRID_MAX
//   - pick_button() : priority encoder start > a > b > up > down > left > right
package sudoku_pkg;

    localparam int unsigned GRID_MAX = 9;
    localparam int unsigned PW = $clog2(GRID_MAX);
    localparam int unsigned NW = $clog2(GRID_MAX + 1);
    localparam int unsigned CW = $clog2(GRID_MAX * GRID_MAX + 1);

    typedef enum logic [2:0] {
        StIdle       = 3'd0,
        StSelectDiff = 3'd1,
        StLoading    = 3'd2,
        StNavigate   = 3'd3,
        StPickNumber = 3'd4,
        StVictory    = 3'd5,
        StDefeat     = 3'd6,
        StPaused     = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        BtnNone,
        BtnStart,
        BtnA,
        BtnB,
        BtnUp,
        BtnDown,
        BtnLeft,
        BtnRight
    } button_e;

    typedef enum logic [2:0] {
        DirNone,
        DirUp,
        DirDown,
        DirLeft,
        DirRight
    } dir_e;

    // Only the highest-priority pressed button is acted on, even when that button has no
    // meaning in the current state; lower-priority buttons in the same cycle are dropped.
    function automatic button_e pick_button(input logic start, input logic a, input logic b,
                                            input logic up, input logic down,
                                            input logic left, input logic right);
        if (start) return BtnStart;
        if (a)     return BtnA;
        if (b)     return BtnB;
        if (up)    return BtnUp;
        if (down)  return BtnDown;
        if (left)  return BtnLeft;
        if (right) return BtnRight;
        return BtnNone;
    endfunction

endpackage

// File: rtl/cursor_mover.sv
// cursor_mover
//   Combinational next-position calculator for the board cursor. Each axis wraps modulo GRID.
//   Up/down move along the row index (up decrements), left/right along the column index
//   (right increments).
// Ports:
//   row, col           : current cursor position
//   dir                : requested move (DirNone leaves the position unchanged)
//   row_next, col_next : position after the move
module cursor_mover import sudoku_pkg::*; #(
    parameter int unsigned GRID = 9
) (
    input  logic [PW-1:0] row,
    input  logic [PW-1:0] col,
    input  dir_e          dir,
    output logic [PW-1:0] row_next,
    output logic [PW-1:0] col_next
);

    localparam logic [PW-1:0] LAST = PW'(GRID - 1);

    always_comb begin
        row_next = row;
        col_next = col;
        case (dir)
            DirUp:    row_next = (row == '0)   ? LAST : row - PW'(1);
            DirDown:  row_next = (row == LAST) ? '0   : row + PW'(1);
            DirLeft:  col_next = (col == '0)   ? LAST : col - PW'(1);
            DirRight: col_next = (col == LAST) ? '0   : col + PW'(1);
            default:  ;
        endcase
    end

endmodule

// File: rtl/sudoku_game_fsm.sv
// sudoku_game_fsm
//   Game controller for a GRID x GRID sudoku: difficulty selection, map load handshake, cursor
//   navigation, number entry with strike counting, play timer, victory/defeat detection.
//   All outputs are registered. Reset is synchronous, active-high.
//
//   Optional feature: define SUDOKU_PAUSE_EN to let start_button pause (NAVIGATE/PICK_NUMBER ->
//   PAUSED) and resume (PAUSED -> NAVIGATE); the timer is frozen while paused. Without the macro,
//   PAUSED is unreachable and start_button is ignored during play.
//
// Ports:
//   clk, reset                : clock, synchronous active-high reset
//   *_button                  : single-cycle button pulses (start, a, b, up, down, left, right)
//   tick_1hz                  : one pulse per second, advances the play timer
//   load_done, hidden_init    : map loader finished, hidden cell count of the loaded map
//   cell_value, cell_visible  : solution value / revealed flag of the cell under the cursor
//   load_req                  : one-cycle map load request
//   wr_en                     : one-cycle reveal of the cell under the cursor
//   error                     : one-cycle pulse on a wrong placement
//   pos_i, pos_j              : cursor row / column
//   difficulty, selected_number, strikes, minutes, seconds, state : game status
module sudoku_game_fsm import sudoku_pkg::*; #(
    parameter int unsigned GRID               = 9,
    parameter int unsigned DIFF_LEVELS        = 3,
    parameter int unsigned MAX_STRIKES        = 3,
    parameter int unsigned TIME_LIMIT_MINUTES = 5,
    localparam int unsigned DW                = $clog2(DIFF_LEVELS),
    localparam int unsigned SW                = $clog2(MAX_STRIKES + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          up_button,
    input  logic          down_button,
    input  logic          left_button,
    input  logic          right_button,
    input  logic          start_button,
    input  logic          a_button,
    input  logic          b_button,
    input  logic          tick_1hz,
    input  logic          load_done,
    input  logic [CW-1:0] hidden_init,
    input  logic [NW-1:0] cell_value,
    input  logic          cell_visible,
    output logic          load_req,
    output logic          wr_en,
    output logic          error,
    output logic [PW-1:0] pos_i,
    output logic [PW-1:0] pos_j,
    output logic [DW-1:0] difficulty,
    output logic [NW-1:0] selected_number,
    output logic [SW-1:0] strikes,
    output logic [7:0]    minutes,
    output logic [5:0]    seconds,
    output logic [2:0]    state
);

    localparam logic [DW-1:0] DIFF_LAST  = DW'(DIFF_LEVELS - 1);
    localparam logic [NW-1:0] NUM_LAST   = NW'(GRID);
    localparam logic [SW-1:0] STRIKE_MAX = SW'(MAX_STRIKES);
    localparam logic [7:0]    TIME_LIMIT = 8'(TIME_LIMIT_MINUTES);

    state_e        state_q;
    logic [CW-1:0] hidden_q;
    button_e       btn;
    dir_e          dir;
    logic [PW-1:0] row_next;
    logic [PW-1:0] col_next;
    logic          in_play;
    logic          lost;
    logic          won;

    assign state = state_q;

    assign btn = pick_button(start_button, a_button, b_button, up_button, down_button,
                             left_button, right_button);

    always_comb begin
        dir = DirNone;
        case (btn)
            BtnUp:    dir = DirUp;
            BtnDown:  dir = DirDown;
            BtnLeft:  dir = DirLeft;
            BtnRight: dir = DirRight;
            default:  dir = DirNone;
        endcase
    end

    cursor_mover #(
        .GRID(GRID)
    ) u_cursor (
        .row     (pos_i),
        .col     (pos_j),
        .dir     (dir),
        .row_next(row_next),
        .col_next(col_next)
    );

    // End-of-game conditions are evaluated on registered status, so the transition lands one
    // cycle after the last placement / strike / minute that caused it. Defeat outranks victory.
    assign in_play = (state_q == StNavigate) || (state_q == StPickNumber);
    assign lost    = (in_play || (state_q == StPaused)) &&
                     ((strikes == STRIKE_MAX) ||
                      ((difficulty != '0) && (minutes >= TIME_LIMIT)));
    assign won     = in_play && (hidden_q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StIdle;
            hidden_q        <= '0;
            pos_i           <= '0;
            pos_j           <= '0;
            difficulty      <= '0;
            selected_number <= NW'(1);
            strikes         <= '0;
            minutes         <= '0;
            seconds         <= '0;
            load_req        <= 1'b0;
            wr_en           <= 1'b0;
            error           <= 1'b0;
        end else begin
            load_req <= 1'b0;
            wr_en    <= 1'b0;
            error    <= 1'b0;

            // Timer runs only during play; PAUSED is excluded so it stays frozen there.
            if (tick_1hz && in_play) begin
                if (seconds == 6'd59) begin
                    seconds <= '0;
                    if (minutes != 8'hff) begin
                        minutes <= minutes + 8'd1;
                    end
                end else begin
                    seconds <= seconds + 6'd1;
                end
            end

            if (lost) begin
                state_q <= StDefeat;
            end else if (won) begin
                state_q <= StVictory;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (btn == BtnStart) state_q <= StSelectDiff;
                    end

                    StSelectDiff: begin
                        case (btn)
                            BtnUp:   difficulty <= (difficulty == DIFF_LAST) ? '0
                                                                             : difficulty + DW'(1);
                            BtnDown: difficulty <= (difficulty == '0) ? DIFF_LAST
                                                                      : difficulty - DW'(1);
                            BtnA: begin
                                // Fresh game: clear everything the previous game left behind.
                                state_q         <= StLoading;
                                load_req        <= 1'b1;
                                pos_i           <= '0;
                                pos_j           <= '0;
                                strikes         <= '0;
                                minutes         <= '0;
                                seconds         <= '0;
                                selected_number <= NW'(1);
                            end
                            default: ;
                        endcase
                    end

                    StLoading: begin
                        if (load_done) begin
                            hidden_q <= hidden_init;
                            state_q  <= StNavigate;
                        end
                    end

                    StNavigate: begin
                        case (btn)
`ifdef SUDOKU_PAUSE_EN
                            BtnStart: state_q <= StPaused;
`endif
                            BtnA: begin
                                if (!cell_visible) state_q <= StPickNumber;
                            end
                            BtnUp, BtnDown, BtnLeft, BtnRight: begin
                                pos_i <= row_next;
                                pos_j <= col_next;
                            end
                            default: ;
                        endcase
                    end

                    StPickNumber: begin
                        case (btn)
`ifdef SUDOKU_PAUSE_EN
                            BtnStart: state_q <= StPaused;
`endif
                            BtnA: begin
                                if (selected_number == cell_value) begin
                                    wr_en    <= 1'b1;
                                    hidden_q <= hidden_q - CW'(1);
                                    state_q  <= StNavigate;
                                end else begin
                                    error <= 1'b1;
                                    if (strikes != STRIKE_MAX) strikes <= strikes + SW'(1);
                                end
                            end
                            BtnB: state_q <= StNavigate;
                            BtnUp: selected_number <= (selected_number == NUM_LAST) ? NW'(1)
                                                          : selected_number + NW'(1);
                            BtnDown: selected_number <= (selected_number <= NW'(1)) ? NUM_LAST
                                                            : selected_number - NW'(1);
                            default: ;
                        endcase
                    end

                    StVictory, StDefeat: begin
                        if (btn == BtnStart) state_q <= StSelectDiff;
                    end

                    StPaused: begin
`ifdef SUDOKU_PAUSE_EN
                        if (btn == BtnStart) state_q <= StNavigate;
`endif
                    end
                endcase
            end
        end
    end

endmodule
